// File: rtl/regfile_ctrl_pkg.sv
// Shared defaults, opcode and FSM state encodings for the register-file controller.
package regfile_ctrl_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLL = 3'b100,
    OP_SRL = 3'b101,
    OP_SRA = 3'b110,
    OP_LDI = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    EX   = 2'b10,
    WB   = 2'b11
  } state_e;

  function automatic logic is_shift_op(input opcode_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  function automatic logic uses_rt(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU for the register-file controller; LDI passes operand b through.
module regfile_alu
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        shamt,
  output logic [DATA_W-1:0] result
);

  logic signed [DATA_W-1:0] a_s;

  assign a_s = a;

  always_comb begin
    result = '0;
    case (opcode_e'(op))
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_SLL:  result = a << shamt;
      OP_SRL:  result = a >> shamt;
      OP_SRA:  result = a_s >>> shamt;
      OP_LDI:  result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Four-state (IDLE/RD/EX/WB) instruction sequencer driving an external register file.
// Shift ops (SLL/SRL/SRA) are legal only when REGFILE_CTRL_SHIFT_EN is defined.
module regfile_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_rd,
  input  logic [ADDR_W-1:0] instr_rs,
  input  logic [ADDR_W-1:0] instr_rt,
  input  logic [DATA_W-1:0] instr_imm,
  output logic              done,
  output logic              err,
  output logic              rf_readA,
  output logic              rf_readB,
  output logic [ADDR_W-1:0] rf_rdAddrA,
  output logic [ADDR_W-1:0] rf_rdAddrB,
  input  logic [DATA_W-1:0] rf_rdDataA,
  input  logic [DATA_W-1:0] rf_rdDataB,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wrAddr,
  output logic [DATA_W-1:0] rf_wrData,
  output logic              rf_wshift,
  output logic [DATA_W-1:0] rf_shData
);

`ifdef REGFILE_CTRL_SHIFT_EN
  localparam logic SHIFT_EN = 1'b1;
`else
  localparam logic SHIFT_EN = 1'b0;
`endif

  state_e            state, state_nxt;
  opcode_e           op_q;
  logic [ADDR_W-1:0] rd_q, rs_q, rt_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [DATA_W-1:0] alu_b, alu_res;
  logic              shift_op, illegal;

  assign shift_op = is_shift_op(op_q);
  assign illegal  = shift_op && !SHIFT_EN;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    rf_readA    = 1'b0;
    rf_readB    = 1'b0;
    rf_write    = 1'b0;
    rf_wshift   = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = RD;
      end
      RD: begin
        rf_readA  = (op_q != OP_LDI) && !illegal;
        rf_readB  = uses_rt(op_q);
        state_nxt = EX;
      end
      EX: state_nxt = WB;
      WB: begin
        rf_write  = !shift_op;
        rf_wshift = shift_op && SHIFT_EN;
        done      = 1'b1;
        err       = illegal;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Instruction fields are captured on the accepting edge and held until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_ADD;
      rd_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
    end else if (instr_valid && instr_ready) begin
      op_q  <= opcode_e'(instr_op);
      rd_q  <= instr_rd;
      rs_q  <= instr_rs;
      rt_q  <= instr_rt;
      imm_q <= instr_imm;
    end
  end

  assign rf_rdAddrA = rs_q;
  assign rf_rdAddrB = rt_q;
  assign rf_wrAddr  = rd_q;
  assign alu_b      = (op_q == OP_LDI) ? imm_q : rf_rdDataB;

  regfile_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op_q),
    .a      (rf_rdDataA),
    .b      (alu_b),
    .shamt  (imm_q[3:0]),
    .result (alu_res)
  );

  // EX: register read data arrives this cycle; the result is held until the next WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       wr_data_q <= '0;
    else if (state == EX && !shift_op) wr_data_q <= alu_res;
  end

  assign rf_wrData = wr_data_q;

`ifdef REGFILE_CTRL_SHIFT_EN
  logic [DATA_W-1:0] sh_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      sh_data_q <= '0;
    else if (state == EX && shift_op) sh_data_q <= alu_res;
  end

  assign rf_shData = sh_data_q;
`else
  assign rf_shData = '0;
`endif

endmodule

// File: tb/tb_regfile_ctrl.sv
// Directed bench for regfile_ctrl paired with a behavioural 32x16 register file.
module tb_regfile_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  instr_op;
  logic [4:0]  instr_rd, instr_rs, instr_rt;
  logic [15:0] instr_imm;
  logic        done, err;
  logic        rf_readA, rf_readB;
  logic [4:0]  rf_rdAddrA, rf_rdAddrB;
  logic [15:0] rf_rdDataA = 16'h0;
  logic [15:0] rf_rdDataB = 16'h0;
  logic        rf_write, rf_wshift;
  logic [4:0]  rf_wrAddr;
  logic [15:0] rf_wrData, rf_shData;

  logic [15:0] rf [32] = '{default: 16'h0};
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd, rs, rt;
    logic [15:0] imm;
    logic        rda, rdb, err, wr, ws;
    logic [15:0] val;
  } vec_t;

  vec_t vecs [10];

  regfile_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs    (instr_rs),
    .instr_rt    (instr_rt),
    .instr_imm   (instr_imm),
    .done        (done),
    .err         (err),
    .rf_readA    (rf_readA),
    .rf_readB    (rf_readB),
    .rf_rdAddrA  (rf_rdAddrA),
    .rf_rdAddrB  (rf_rdAddrB),
    .rf_rdDataA  (rf_rdDataA),
    .rf_rdDataB  (rf_rdDataB),
    .rf_write    (rf_write),
    .rf_wrAddr   (rf_wrAddr),
    .rf_wrData   (rf_wrData),
    .rf_wshift   (rf_wshift),
    .rf_shData   (rf_shData)
  );

  always #5 clk = ~clk;

  // Registered-read register file plus event counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rf_readA)  rf_rdDataA <= rf[rf_rdAddrA];
    if (rf_readB)  rf_rdDataB <= rf[rf_rdAddrB];
    if (rf_write)  rf[rf_wrAddr] <= rf_wrData;
    if (rf_wshift) rf[rf_wrAddr] <= rf_shData;
    if (rf_write || rf_wshift) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [4:0] rd, rs, rt,
                              input logic [15:0] imm, input logic rda, rdb, e, wr, ws,
                              input logic [15:0] val);
    vec_t v;
    v.op = op; v.rd = rd; v.rs = rs; v.rt = rt; v.imm = imm;
    v.rda = rda; v.rdb = rdb; v.err = e; v.wr = wr; v.ws = ws; v.val = val;
    return v;
  endfunction

  task automatic set_instr(input logic [2:0] op, input logic [4:0] rd, rs, rt,
                           input logic [15:0] imm);
    instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt; instr_imm = imm;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit rdy = 0;
    for (int i = 0; i < 10 && !rdy; i++) begin
      @(negedge clk);
      rdy = instr_ready;
    end
    chk($sformatf("v%0d_ready", idx), rdy, 1'b1);
    set_instr(v.op, v.rd, v.rs, v.rt, v.imm);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_reads", idx), {rf_readA, rf_readB}, {v.rda, v.rdb});
    if (v.rda) chk($sformatf("v%0d_addrA", idx), rf_rdAddrA, v.rs);
    if (v.rdb) chk($sformatf("v%0d_addrB", idx), rf_rdAddrB, v.rt);
    @(negedge clk);
    chk($sformatf("v%0d_ex_quiet", idx), {done, rf_write, rf_wshift}, 3'b000);
    @(negedge clk);
    chk($sformatf("v%0d_wb", idx), {done, err, rf_write, rf_wshift}, {1'b1, v.err, v.wr, v.ws});
    if (v.wr || v.ws) chk($sformatf("v%0d_wraddr", idx), rf_wrAddr, v.rd);
    if (v.ws) chk($sformatf("v%0d_shdata", idx), rf_shData, v.val);
    @(negedge clk);
    chk($sformatf("v%0d_result", idx), rf[v.rd], v.val);
    chk($sformatf("v%0d_done_pulse", idx), {done, err}, 2'b00);
  endtask

  initial begin
    int acc [3];
    int idx;
    int wr0, dn0;

    vecs[0] = mk(3'b111, 5'd1, 5'd0, 5'd0, 16'h7FFF, 0, 0, 0, 1, 0, 16'h7FFF);
    vecs[1] = mk(3'b111, 5'd2, 5'd0, 5'd0, 16'h0001, 0, 0, 0, 1, 0, 16'h0001);
    vecs[2] = mk(3'b000, 5'd3, 5'd1, 5'd2, 16'h0000, 1, 1, 0, 1, 0, 16'h8000);
    vecs[3] = mk(3'b001, 5'd4, 5'd2, 5'd1, 16'h0000, 1, 1, 0, 1, 0, 16'h8002);
    vecs[4] = mk(3'b010, 5'd7, 5'd1, 5'd4, 16'h0000, 1, 1, 0, 1, 0, 16'h0002);
    vecs[5] = mk(3'b011, 5'd8, 5'd2, 5'd3, 16'h0000, 1, 1, 0, 1, 0, 16'h8001);
`ifdef REGFILE_CTRL_SHIFT_EN
    vecs[6] = mk(3'b110, 5'd5, 5'd3, 5'd0, 16'h00F4, 1, 0, 0, 0, 1, 16'hF800);
    vecs[7] = mk(3'b101, 5'd9, 5'd3, 5'd0, 16'h0004, 1, 0, 0, 0, 1, 16'h0800);
    vecs[8] = mk(3'b100, 5'd10, 5'd2, 5'd0, 16'h000F, 1, 0, 0, 0, 1, 16'h8000);
`else
    vecs[6] = mk(3'b110, 5'd5, 5'd3, 5'd0, 16'h00F4, 0, 0, 1, 0, 0, 16'h0000);
    vecs[7] = mk(3'b101, 5'd9, 5'd3, 5'd0, 16'h0004, 0, 0, 1, 0, 0, 16'h0000);
    vecs[8] = mk(3'b100, 5'd10, 5'd2, 5'd0, 16'h000F, 0, 0, 1, 0, 0, 16'h0000);
`endif
    vecs[9] = mk(3'b111, 5'd0, 5'd0, 5'd0, 16'h1234, 0, 0, 0, 1, 0, 16'h1234);

    rst_n = 1'b0;
    instr_valid = 1'b0;
    set_instr(3'b000, 5'd0, 5'd0, 5'd0, 16'h0);
    #12;
    chk("reset_outputs",
        {instr_ready, done, err, rf_readA, rf_readB, rf_write, rf_wshift,
         rf_rdAddrA, rf_rdAddrB, rf_wrAddr, rf_wrData, rf_shData},
        {1'b1, 6'b0, 15'b0, 32'b0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    @(negedge clk);
    chk("wrdata_hold", {rf_write, rf_wshift, rf_wrData}, {2'b00, 16'h1234});

    // Three dependent ADDs with instr_valid held high.
    idx = 0;
    set_instr(3'b000, 5'd11, 5'd2, 5'd2, 16'h0);
    instr_valid = 1'b1;
    for (int c = 0; c < 40 && idx < 3; c++) begin
      @(negedge clk);
      if (instr_ready) begin
        acc[idx] = cyc;
        idx++;
        @(posedge clk);
        #1;
        if (idx == 1)      set_instr(3'b000, 5'd12, 5'd11, 5'd2, 16'h0);
        else if (idx == 2) set_instr(3'b000, 5'd13, 5'd12, 5'd12, 16'h0);
        else               instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk("b2b_accepts", idx, 3);
    if (idx == 3) begin
      chk("b2b_space1", acc[1] - acc[0], 4);
      chk("b2b_space2", acc[2] - acc[1], 4);
    end
    repeat (5) @(negedge clk);
    chk("b2b_r11", rf[11], 16'h0002);
    chk("b2b_r12", rf[12], 16'h0003);
    chk("b2b_r13", rf[13], 16'h0006);

    // Reset during EX of ADD r6 aborts the instruction.
    @(negedge clk);
    chk("abort_ready", instr_ready, 1'b1);
    set_instr(3'b000, 5'd6, 5'd1, 5'd2, 16'h0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    wr0 = wr_cnt;
    dn0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_in_reset", {instr_ready, done, err, rf_write, rf_wshift, rf_wrData},
        {1'b1, 4'b0, 16'h0});
    repeat (2) @(negedge clk);
    chk("abort_ready_held", instr_ready, 1'b1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_write", wr_cnt - wr0, 0);
    chk("abort_no_done", done_cnt - dn0, 0);
    chk("abort_r6", rf[6], 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, 16, register data width; ADDR_W, 5, register address width.
REQ-002 Ports SHALL be, in order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr_op  in  3  opcode
- instr_rd / instr_rs / instr_rt  in  ADDR_W each  destination / source A / source B
- instr_imm  in  DATA_W  LDI value; [3:0] = shift amount
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-op pulse, coincident with done
- rf_readA, rf_readB  out  1 each  register-file read enables
- rf_rdAddrA, rf_rdAddrB  out  ADDR_W each  read addresses
- rf_rdDataA, rf_rdDataB  in  DATA_W each  registered read data, valid the cycle after the enable
- rf_write  out  1  write enable
- rf_wrAddr  out  ADDR_W  write/shift-write address
- rf_wrData  out  DATA_W  write data
- rf_wshift  out  1  shift-result write enable
- rf_shData  out  DATA_W  shift-result data
REQ-003 There SHALL be one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-004 Opcodes SHALL be: 000 ADD rd=rs+rt; 001 SUB rd=rs-rt; 010 AND; 011 OR; 100 SLL rd=rs<<imm[3:0]; 101 SRL (logical); 110 SRA (arithmetic); 111 LDI rd=instr_imm.
REQ-005 Arithmetic SHALL wrap modulo 2^DATA_W, with no carry or overflow output.
REQ-006 FSM states SHALL be IDLE, RD, EX, WB. Transitions: IDLE->RD on instr_valid&&instr_ready; RD->EX; EX->WB; WB->IDLE, unconditionally.
REQ-007 instr_ready SHALL be 1 only in IDLE; op, rd, rs, rt and imm SHALL be latched on the accepting edge.
REQ-008 In RD the block SHALL assert rf_readA (rdAddrA=rs) for ops 000-110, and rf_readB (rdAddrB=rt) for ops 000-011 only; no reads for LDI.
REQ-009 In EX the block SHALL register the op result from rf_rdDataA/rf_rdDataB, or from imm for LDI.
REQ-010 In WB the block SHALL assert rf_write (ops 000-011, 111) or rf_wshift (ops 100-110) for exactly one cycle, with rf_wrAddr=rd, and pulse done.
REQ-011 rf_write and rf_wshift SHALL never be high together.
REQ-012 Latency SHALL be fixed: accepted at edge N, done high in cycle N+3, next accept possible at edge N+4.
REQ-013 Back-to-back dependent instructions SHALL see the prior result with no forwarding, because the WB write edge precedes the next RD.
REQ-014 Writes to any address, including 0, SHALL be issued unchanged.
REQ-015 When not in WB, rf_wrData and rf_shData SHALL hold their last value, and all enables SHALL be 0.

Reset
REQ-016 On rst_n low, state SHALL go to IDLE immediately, with instr_ready=1 and all other outputs 0, including data/address outputs.
REQ-017 Reset asserted mid-operation SHALL abort the instruction: no write, no done, no err.

Configuration
REQ-018 With REGFILE_CTRL_SHIFT_EN defined, ops 100-110 SHALL execute per REQ-004.
REQ-019 Without REGFILE_CTRL_SHIFT_EN, ops 100-110 SHALL be illegal: no reads and no write, err and done pulse in WB, and rf_wshift and rf_shData tied to 0.

Structure
REQ-020 Package regfile_ctrl_pkg SHALL hold DATA_W/ADDR_W defaults, the opcode enum and the FSM state enum.
REQ-021 Sub-module regfile_alu SHALL be combinational (op, a, b, shamt -> result); the FSM and registers stay in regfile_ctrl.

Verification
REQ-022 The bench SHALL pair the DUT with a behavioural 32x16 register file and cover:
- LDI r1=0x7FFF, LDI r2=0x0001, ADD r3=r1+r2 -> r3=0x8000, done 3 cycles after each accept, err=0.
- SUB r4=r2-r1 with r1=0x7FFF, r2=0x0001 -> r4=0x8002 (wraps).
- SRA r5=r3>>4 with r3=0x8000 -> rf_wshift=1, rf_write=0, r5=0xF800; SRL gives 0x0800; SLL by 15 of 0x0001 gives 0x8000.
- Same SRA without REGFILE_CTRL_SHIFT_EN -> err=1, done=1, no enable, r5 unchanged.
- instr_valid held high for 3 dependent ADDs -> accepts spaced exactly 4 cycles, each result correct.
- rst_n low during EX of ADD r6 -> no write, r6 stays 0, instr_ready=1 while in reset.
